tx_dma_trans_buffer: RTL and testbench

- Transaction buffer for the TX DMA direction; the counterpart of the RX transaction buffer.
- Write side: PCIe completion payload written dword-addressed, with per-dword enables, into a circular on-chip buffer.
- Read side: on a request (start address, length), reads the payload out, realigned so the first dword sits at item 0, as a single-region MFB stream toward the user TX port.
- Sits between the PCIe completion parser and the TX DMA packet dispatcher.

---
 rtl/tx_dma_trans_buffer.sv | 222 ++++++++++++++++++++++
 tb/tb_tx_dma_trans_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_dma_trans_buffer.sv
// TX DMA transaction buffer: dword-enabled circular write store, read back as a
// realigned single-region MFB stream through a 2-entry output skid buffer.
module tx_dma_trans_buffer #(
    parameter int unsigned BLOCK_SIZE   = 8,
    parameter int unsigned ITEM_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 512,
    parameter int unsigned LEN_WIDTH    = 11,
    localparam int unsigned DW  = BLOCK_SIZE * ITEM_WIDTH,
    localparam int unsigned IW  = $clog2(BLOCK_SIZE),
    localparam int unsigned WAW = $clog2(BUFFER_DEPTH),
    localparam int unsigned AW  = WAW + IW
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 WR_EN,
    input  logic [WAW-1:0]       WR_ADDR,
    input  logic [DW-1:0]        WR_DATA,
    input  logic [BLOCK_SIZE-1:0] WR_BE,
    input  logic [AW-1:0]        RD_REQ_ADDR,
    input  logic [LEN_WIDTH-1:0] RD_REQ_LEN,
    input  logic                 RD_REQ_VLD,
    output logic                 RD_REQ_RDY,
    output logic [DW-1:0]        TX_MFB_DATA,
    output logic                 TX_MFB_SOF_POS,
    output logic [IW-1:0]        TX_MFB_EOF_POS,
    output logic                 TX_MFB_SOF,
    output logic                 TX_MFB_EOF,
    output logic                 TX_MFB_SRC_RDY,
    input  logic                 TX_MFB_DST_RDY
);
    localparam int unsigned CW = LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eof;
        logic [IW-1:0] eof_pos;
    } beat_t;

    logic [DW-1:0] mem [BUFFER_DEPTH];
    logic [DW-1:0] rd_data_q;

    state_t               state_q, state_d;
    logic [WAW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]        off_q, off_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [CW-1:0]        n_q, n_d, m_q, m_d;
    logic [CW-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]        cons_cnt_q, cons_cnt_d;
    logic [CW-1:0]        emit_cnt_q, emit_cnt_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [DW-1:0]        prev_q, prev_d;
    logic                 prev_vld_q, prev_vld_d;
    logic                 rdy_q, rdy_d;
    beat_t                ent0_q, ent0_d, ent1_q, ent1_d;
    logic                 vld0_q, vld0_d, vld1_q, vld1_d;

    logic                 pop, room, consume, flush, emit, rd_en;
    logic [2*DW-1:0]      rot;
    beat_t                beat;

    // Payload store: byte-lane style dword enables, read-first on collision
    always_ff @(posedge CLK) begin
        if (WR_EN) begin
            for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
                if (WR_BE[i]) begin
                    mem[WR_ADDR][i*ITEM_WIDTH +: ITEM_WIDTH] <= WR_DATA[i*ITEM_WIDTH +: ITEM_WIDTH];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[ptr_q];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        off_d       = off_q;
        len_d       = len_q;
        n_d         = n_q;
        m_d         = m_q;
        issue_cnt_d = issue_cnt_q;
        cons_cnt_d  = cons_cnt_q;
        emit_cnt_d  = emit_cnt_q;
        rd_vld_d    = rd_vld_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        ent0_d      = ent0_q;
        ent1_d      = ent1_q;
        vld0_d      = vld0_q;
        vld1_d      = vld1_q;

        pop     = vld0_q & TX_MFB_DST_RDY;
        room    = !vld1_q || pop;
        // A fetched word retires into prev; it completes an output word when prev is already filled
        consume = rd_vld_q && (!prev_vld_q || room);
        // Last output word needs only prev when the packet does not spill into another fetched word
        flush   = !rd_vld_q && prev_vld_q && (cons_cnt_q == n_q) && (emit_cnt_q != m_q) && room;
        emit    = (consume && prev_vld_q) || flush;
        rd_en   = (state_q == FETCH) && (issue_cnt_q != n_q) && (!rd_vld_q || consume);

        rot          = {rd_data_q, prev_q} >> (32'(off_q) * ITEM_WIDTH);
        beat.data    = rot[DW-1:0];
        beat.sof     = (emit_cnt_q == '0);
        beat.eof     = (emit_cnt_q == m_q - CW'(1));
        beat.eof_pos = beat.eof ? IW'(len_q - LEN_WIDTH'(1)) : '0;

        if (rd_en) begin
            issue_cnt_d = issue_cnt_q + CW'(1);
            ptr_d       = ptr_q + WAW'(1);
            rd_vld_d    = 1'b1;
        end else if (consume) begin
            rd_vld_d = 1'b0;
        end
        if (consume) begin
            prev_d     = rd_data_q;
            prev_vld_d = 1'b1;
            cons_cnt_d = cons_cnt_q + CW'(1);
        end
        if (emit) begin
            emit_cnt_d = emit_cnt_q + CW'(1);
        end

        // Skid buffer: head shifts out on transfer, new word lands in the first free slot
        if (pop) begin
            ent0_d = ent1_q;
            vld0_d = vld1_q;
            vld1_d = 1'b0;
        end
        if (emit) begin
            if (!vld0_d) begin
                ent0_d = beat;
                vld0_d = 1'b1;
            end else begin
                ent1_d = beat;
                vld1_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (RD_REQ_VLD && rdy_q) begin
                    ptr_d       = RD_REQ_ADDR[AW-1:IW];
                    off_d       = RD_REQ_ADDR[IW-1:0];
                    len_d       = RD_REQ_LEN;
                    n_d         = CW'((CW'(RD_REQ_ADDR[IW-1:0]) + CW'(RD_REQ_LEN) + CW'(BLOCK_SIZE - 1)) >> IW);
                    m_d         = CW'((CW'(RD_REQ_LEN) + CW'(BLOCK_SIZE - 1)) >> IW);
                    issue_cnt_d = '0;
                    cons_cnt_d  = '0;
                    emit_cnt_d  = '0;
                    prev_vld_d  = 1'b0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (rd_en && (issue_cnt_q == n_q - CW'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (emit_cnt_q == m_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            off_q       <= '0;
            len_q       <= '0;
            n_q         <= '0;
            m_q         <= '0;
            issue_cnt_q <= '0;
            cons_cnt_q  <= '0;
            emit_cnt_q  <= '0;
            rd_vld_q    <= 1'b0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            rdy_q       <= 1'b0;
            ent0_q      <= '0;
            ent1_q      <= '0;
            vld0_q      <= 1'b0;
            vld1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            off_q       <= off_d;
            len_q       <= len_d;
            n_q         <= n_d;
            m_q         <= m_d;
            issue_cnt_q <= issue_cnt_d;
            cons_cnt_q  <= cons_cnt_d;
            emit_cnt_q  <= emit_cnt_d;
            rd_vld_q    <= rd_vld_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            rdy_q       <= rdy_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            vld0_q      <= vld0_d;
            vld1_q      <= vld1_d;
        end
    end

    assign RD_REQ_RDY     = rdy_q;
    assign TX_MFB_DATA    = ent0_q.data;
    assign TX_MFB_SOF_POS = 1'b0;
    assign TX_MFB_EOF_POS = ent0_q.eof_pos;
    assign TX_MFB_SOF     = ent0_q.sof;
    assign TX_MFB_EOF     = ent0_q.eof;
    assign TX_MFB_SRC_RDY = vld0_q;

endmodule

// File: tb/tb_tx_dma_trans_buffer.sv
// Bench for tx_dma_trans_buffer: a flat dword-array model of the buffer predicts
// every output word of each randomized or directed read request.
module tb_tx_dma_trans_buffer;
    localparam int unsigned BS    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 11;
    localparam int unsigned DW    = BS * 32;
    localparam int unsigned WAW   = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned TOT   = DEPTH * BS;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              WR_EN = 1'b0;
    logic [WAW-1:0]    WR_ADDR = '0;
    logic [DW-1:0]     WR_DATA = '0;
    logic [BS-1:0]     WR_BE = '0;
    logic [AW-1:0]     RD_REQ_ADDR = '0;
    logic [LW-1:0]     RD_REQ_LEN = '0;
    logic              RD_REQ_VLD = 1'b0;
    logic              RD_REQ_RDY;
    logic [DW-1:0]     TX_MFB_DATA;
    logic              TX_MFB_SOF_POS;
    logic [2:0]        TX_MFB_EOF_POS;
    logic              TX_MFB_SOF;
    logic              TX_MFB_EOF;
    logic              TX_MFB_SRC_RDY;
    logic              TX_MFB_DST_RDY = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_mem [TOT];

    tx_dma_trans_buffer #(
        .BLOCK_SIZE(BS), .ITEM_WIDTH(32), .BUFFER_DEPTH(DEPTH), .LEN_WIDTH(LW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_BE(WR_BE),
        .RD_REQ_ADDR(RD_REQ_ADDR), .RD_REQ_LEN(RD_REQ_LEN),
        .RD_REQ_VLD(RD_REQ_VLD), .RD_REQ_RDY(RD_REQ_RDY),
        .TX_MFB_DATA(TX_MFB_DATA), .TX_MFB_SOF_POS(TX_MFB_SOF_POS),
        .TX_MFB_EOF_POS(TX_MFB_EOF_POS), .TX_MFB_SOF(TX_MFB_SOF),
        .TX_MFB_EOF(TX_MFB_EOF), .TX_MFB_SRC_RDY(TX_MFB_SRC_RDY),
        .TX_MFB_DST_RDY(TX_MFB_DST_RDY)
    );

    always #5 CLK = ~CLK;

    task automatic wr_word(input int a, input logic [DW-1:0] d, input logic [BS-1:0] be);
        WR_EN = 1'b1; WR_ADDR = WAW'(a); WR_DATA = d; WR_BE = be;
        @(negedge CLK);
        WR_EN = 1'b0; WR_BE = '0;
        for (int i = 0; i < int'(BS); i++)
            if (be[i]) ref_mem[a*BS + i] = d[i*32 +: 32];
    endtask

    task automatic fill_index;
        logic [DW-1:0] d;
        for (int w = 0; w < int'(DEPTH); w++) begin
            for (int i = 0; i < int'(BS); i++) d[i*32 +: 32] = 32'(w*BS + i);
            wr_word(w, d, '1);
        end
    endtask

    task automatic fill_random;
        logic [DW-1:0] d;
        for (int w = 0; w < int'(DEPTH); w++) begin
            for (int i = 0; i < int'(BS); i++) d[i*32 +: 32] = $urandom;
            wr_word(w, d, '1);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!RD_REQ_RDY && n < 200) begin
            @(negedge CLK); n++;
        end
        vectors++;
        if (!RD_REQ_RDY) begin
            miscompares++;
            $display("FAIL %s req_rdy_timeout: RD_REQ_RDY=%0b required 1", tag, RD_REQ_RDY);
        end
    endtask

    // Issue one request and check every output word against the dword model
    task automatic run_req(input string tag, input int addr, input int len, input bit rnd, input bit chk_lat);
        int m, k, cyc;
        bit first, holding;
        logic [DW+4:0] held;
        logic [DW-1:0] exp_d, mask;
        m = (len + 7) / 8;
        wait_rdy(tag);
        RD_REQ_ADDR = AW'(addr); RD_REQ_LEN = LW'(len); RD_REQ_VLD = 1'b1;
        TX_MFB_DST_RDY = 1'b1;
        @(negedge CLK);
        RD_REQ_VLD = 1'b0;
        cyc = 1;
        vectors++;
        if (RD_REQ_RDY !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_rdy: RD_REQ_RDY=%0b required 0", tag, RD_REQ_RDY);
        end
        TX_MFB_DST_RDY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        k = 0; first = 1'b1; holding = 1'b0; held = '0;
        while (k < m && cyc < 3000) begin
            if (TX_MFB_SRC_RDY) begin
                if (first) begin
                    first = 1'b0;
                    if (chk_lat) begin
                        vectors++;
                        if (cyc - 1 != 3) begin
                            miscompares++;
                            $display("FAIL %s latency: got %0d cycles required 3", tag, cyc - 1);
                        end
                    end
                end
                if (holding) begin
                    vectors++;
                    if ({TX_MFB_DATA, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_EOF_POS} !== held) begin
                        miscompares++;
                        $display("FAIL %s stall_stable word %0d: outputs changed while stalled", tag, k);
                    end
                end
                if (TX_MFB_DST_RDY) begin
                    exp_d = '0; mask = '0;
                    for (int i = 0; i < int'(BS); i++) begin
                        if (k*8 + i < len) begin
                            exp_d[i*32 +: 32] = ref_mem[(addr + k*8 + i) % TOT];
                            mask[i*32 +: 32]  = '1;
                        end
                    end
                    vectors++;
                    if ((TX_MFB_DATA & mask) !== exp_d) begin
                        miscompares++;
                        $display("FAIL %s data word %0d: got %h required %h", tag, k, TX_MFB_DATA & mask, exp_d);
                    end
                    vectors++;
                    if (TX_MFB_SOF !== (k == 0) || TX_MFB_EOF !== (k == m - 1)) begin
                        miscompares++;
                        $display("FAIL %s sof_eof word %0d: got sof=%0b eof=%0b required sof=%0b eof=%0b",
                                 tag, k, TX_MFB_SOF, TX_MFB_EOF, k == 0, k == m - 1);
                    end
                    if (k == m - 1) begin
                        vectors++;
                        if (TX_MFB_EOF_POS !== 3'((len - 1) % 8)) begin
                            miscompares++;
                            $display("FAIL %s eof_pos: got %0d required %0d", tag, TX_MFB_EOF_POS, (len - 1) % 8);
                        end
                    end
                    k++;
                    holding = 1'b0;
                end else begin
                    held = {TX_MFB_DATA, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_EOF_POS};
                    holding = 1'b1;
                end
            end
            @(negedge CLK);
            cyc++;
            TX_MFB_DST_RDY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        vectors++;
        if (k != m) begin
            miscompares++;
            $display("FAIL %s word_count: got %0d required %0d", tag, k, m);
        end
        TX_MFB_DST_RDY = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (TX_MFB_SRC_RDY !== 1'b0) begin
            miscompares++;
            $display("FAIL %s extra_word: SRC_RDY=%0b required 0", tag, TX_MFB_SRC_RDY);
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({RD_REQ_RDY, TX_MFB_SRC_RDY, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_EOF_POS, TX_MFB_SOF_POS} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%0b src=%0b sof=%0b eof=%0b eof_pos=%0d sof_pos=%0b required all 0",
                     RD_REQ_RDY, TX_MFB_SRC_RDY, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_EOF_POS, TX_MFB_SOF_POS);
        end
        RST = 1'b1;
        @(negedge CLK);
        vectors++;
        if (RD_REQ_RDY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_rdy: got %0b required 1", RD_REQ_RDY);
        end
    endtask

    task automatic test_aligned;
        fill_index();
        run_req("aligned", 0, 16, 1'b0, 1'b1);
    endtask

    task automatic test_unaligned;
        run_req("unaligned_single", 3, 5, 1'b0, 1'b1);
        run_req("unaligned_span", 5, 12, 1'b0, 1'b1);
    endtask

    task automatic test_wrap;
        run_req("wrap", 30, 6, 1'b0, 1'b1);
    endtask

    task automatic test_partial_write;
        logic [DW-1:0] a, b;
        for (int i = 0; i < int'(BS); i++) begin
            a[i*32 +: 32] = 32'hA;
            b[i*32 +: 32] = 32'hB;
        end
        wr_word(0, a, '1);
        wr_word(0, b, 8'h0F);
        run_req("partial_write", 0, 8, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure;
        fill_random();
        run_req("backpressure", 0, 100, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++)
            run_req("backpressure_rnd", int'($urandom_range(0, TOT - 1)), 100, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 12; r++)
            run_req("back_to_back", int'($urandom_range(0, TOT - 1)), int'($urandom_range(1, 40)), 1'b0, 1'b1);
        for (int r = 0; r < 8; r++)
            run_req("rand_stall", int'($urandom_range(0, TOT - 1)), int'($urandom_range(1, 60)), 1'b1, 1'b0);
    endtask

    task automatic test_reset_midpacket;
        wait_rdy("reset_mid");
        RD_REQ_ADDR = AW'($urandom_range(0, TOT - 1)); RD_REQ_LEN = LW'(100); RD_REQ_VLD = 1'b1;
        TX_MFB_DST_RDY = 1'b1;
        @(negedge CLK);
        RD_REQ_VLD = 1'b0;
        repeat (6) @(negedge CLK);
        vectors++;
        if (TX_MFB_SRC_RDY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_streaming: SRC_RDY=%0b required 1", TX_MFB_SRC_RDY);
        end
        RST = 1'b0;
        #1;
        vectors++;
        if (TX_MFB_SRC_RDY !== 1'b0 || TX_MFB_EOF !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_drop: SRC_RDY=%0b EOF=%0b required 0 0", TX_MFB_SRC_RDY, TX_MFB_EOF);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        vectors++;
        if (RD_REQ_RDY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_rdy: got %0b required 1", RD_REQ_RDY);
        end
        run_req("after_reset", int'($urandom_range(0, TOT - 1)), 23, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < int'(TOT); i++) ref_mem[i] = '0;
        test_reset();
        test_aligned();
        test_unaligned();
        test_wrap();
        test_partial_write();
        test_backpressure();
        test_back_to_back();
        test_reset_midpacket();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
